// File: rtl/mdu_pkg.sv
// Shared types and helpers for the multiply/divide unit.
// Op encodings, FSM states and counter sizing are defined here.
package mdu_pkg;

   localparam int CNT_W = 8;

   typedef enum logic [3:0] {
      MULT  = 4'd0,
      MULTU = 4'd1,
      DIV   = 4'd2,
      DIVU  = 4'd3,
      MADD  = 4'd4,
      MADDU = 4'd5,
      MSUB  = 4'd6,
      MSUBU = 4'd7,
      MTHI  = 4'd8,
      MTLO  = 4'd9
   } op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   function automatic logic is_valid_op(input logic [3:0] op);
      return op <= MTLO;
   endfunction

   // Every multi-cycle class sits below MTHI in the encoding.
   function automatic logic is_long_op(input logic [3:0] op);
      return op <= MSUBU;
   endfunction

   function automatic logic is_div_op(input logic [3:0] op);
      return (op == DIV) || (op == DIVU);
   endfunction

endpackage

// File: rtl/mdu_multi_if.sv
// Issue/result bundle between E-stage control and the multiply/divide unit.
// The master drives the request side; the unit (slave) drives HI/LO/busy.
interface mdu_multi_if #(
   parameter int WIDTH = 32
) ();

   logic             start;
   logic [3:0]       op;
   logic [WIDTH-1:0] d1;
   logic [WIDTH-1:0] d2;
   logic             kill;
   logic [WIDTH-1:0] HI;
   logic [WIDTH-1:0] LO;
   logic             busy;

   modport master (
      output start, op, d1, d2, kill,
      input  HI, LO, busy
   );

   modport slave (
      input  start, op, d1, d2, kill,
      output HI, LO, busy
   );

endinterface

// File: rtl/mdu_calc.sv
// Combinational datapath: produces the 2*WIDTH {HI,LO} result of a long op
// from the operands and the current HI/LO, plus a divide-by-zero flag.
module mdu_calc
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [3:0]         i_op,
   input  logic [WIDTH-1:0]   i_d1,
   input  logic [WIDTH-1:0]   i_d2,
   input  logic [WIDTH-1:0]   i_hi,
   input  logic [WIDTH-1:0]   i_lo,
   output logic [2*WIDTH-1:0] o_res,
   output logic               o_div_zero
);

   localparam int PW = 2 * WIDTH;

   logic [PW-1:0]    w_acc;
   logic [PW-1:0]    w_prod_s;
   logic [PW-1:0]    w_prod_u;
   logic             w_signed_div;
   logic             w_sgn1;
   logic             w_sgn2;
   logic [WIDTH-1:0] w_abs1;
   logic [WIDTH-1:0] w_abs2;
   logic [WIDTH-1:0] w_dvd;
   logic [WIDTH-1:0] w_dvs;
   logic [WIDTH-1:0] w_q;
   logic [WIDTH-1:0] w_r;
   logic [WIDTH-1:0] w_sq;
   logic [WIDTH-1:0] w_sr;

   assign w_acc    = {i_hi, i_lo};
   assign w_prod_s = {{WIDTH{i_d1[WIDTH-1]}}, i_d1} * {{WIDTH{i_d2[WIDTH-1]}}, i_d2};
   assign w_prod_u = {{WIDTH{1'b0}}, i_d1} * {{WIDTH{1'b0}}, i_d2};

   // One unsigned divider serves both flavours; signed division runs on
   // magnitudes and patches signs afterwards. Most-negative / -1 falls out
   // as quotient 2^(WIDTH-1) with a positive sign, i.e. most-negative again.
   assign w_signed_div = (i_op == DIV);
   assign w_sgn1       = i_d1[WIDTH-1];
   assign w_sgn2       = i_d2[WIDTH-1];
   assign w_abs1       = w_sgn1 ? -i_d1 : i_d1;
   assign w_abs2       = w_sgn2 ? -i_d2 : i_d2;
   assign w_dvd        = w_signed_div ? w_abs1 : i_d1;
   assign w_dvs        = w_signed_div ? w_abs2 : i_d2;
   assign w_q          = (w_dvs == '0) ? '0 : w_dvd / w_dvs;
   assign w_r          = (w_dvs == '0) ? '0 : w_dvd % w_dvs;
   assign w_sq         = (w_sgn1 ^ w_sgn2) ? -w_q : w_q;
   assign w_sr         = w_sgn1 ? -w_r : w_r;

   assign o_div_zero = is_div_op(i_op) && (i_d2 == '0);

   always_comb begin
      o_res = w_acc;
      case (i_op)
         MULT:    o_res = w_prod_s;
         MULTU:   o_res = w_prod_u;
         MADD:    o_res = w_acc + w_prod_s;
         MADDU:   o_res = w_acc + w_prod_u;
         MSUB:    o_res = w_acc - w_prod_s;
         MSUBU:   o_res = w_acc - w_prod_u;
         DIV:     o_res = {w_sr, w_sq};
         DIVU:    o_res = {w_r, w_q};
         default: o_res = w_acc;
      endcase
   end

endmodule

// File: rtl/mdu_multi.sv
// E-stage multiply/divide unit: owns HI/LO, sequences long ops with a latency
// down-counter and exposes busy to the hazard unit. All outputs are registered.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no op in flight; MTHI/MTLO write directly, long ops issue
//   ST_RUN  | long op pending; counter runs down, commit when it reads 1
module mdu_multi
   import mdu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int MUL_LAT = 5,
   parameter int DIV_LAT = 10
) (
   input  logic        i_clk,
   input  logic        i_rst,
   mdu_multi_if.slave  bus
);

   localparam logic [CNT_W-1:0] MUL_LAT_C = CNT_W'(MUL_LAT);
   localparam logic [CNT_W-1:0] DIV_LAT_C = CNT_W'(DIV_LAT);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_e             r_state;
   state_e             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic [2*WIDTH-1:0] r_pend;
   logic [2*WIDTH-1:0] w_pend_nxt;
   logic               r_dz;
   logic               w_dz_nxt;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   w_hi_nxt;
   logic [WIDTH-1:0]   r_lo;
   logic [WIDTH-1:0]   w_lo_nxt;

   logic [2*WIDTH-1:0] w_calc_res;
   logic               w_calc_dz;
   logic               w_issue;

   mdu_calc #(.WIDTH(WIDTH)) u_calc (
      .i_op       (bus.op),
      .i_d1       (bus.d1),
      .i_d2       (bus.d2),
      .i_hi       (r_hi),
      .i_lo       (r_lo),
      .o_res      (w_calc_res),
      .o_div_zero (w_calc_dz)
   );

   assign w_issue = bus.start && is_valid_op(bus.op);

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_pend  <= '0;
         r_dz    <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_pend  <= w_pend_nxt;
         r_dz    <= w_dz_nxt;
         r_hi    <= w_hi_nxt;
         r_lo    <= w_lo_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_pend_nxt  = r_pend;
      w_dz_nxt    = r_dz;
      w_hi_nxt    = r_hi;
      w_lo_nxt    = r_lo;

      // Kill outranks both commit and issue.
      if (bus.kill) begin
         w_state_nxt = ST_IDLE;
         w_cnt_nxt   = '0;
         w_pend_nxt  = '0;
         w_dz_nxt    = 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_issue) begin
                  if (is_long_op(bus.op)) begin
                     w_state_nxt = ST_RUN;
                     w_cnt_nxt   = is_div_op(bus.op) ? DIV_LAT_C : MUL_LAT_C;
                     w_pend_nxt  = w_calc_res;
                     w_dz_nxt    = w_calc_dz;
                  end else if (bus.op == MTHI) begin
                     w_hi_nxt = bus.d1;
                  end else begin
                     w_lo_nxt = bus.d1;
                  end
               end
            end
            ST_RUN: begin
               if (r_cnt == CNT_ONE) begin
                  w_state_nxt = ST_IDLE;
                  w_cnt_nxt   = '0;
                  w_pend_nxt  = '0;
                  w_dz_nxt    = 1'b0;
                  if (!r_dz) begin
                     w_hi_nxt = r_pend[2*WIDTH-1:WIDTH];
                     w_lo_nxt = r_pend[WIDTH-1:0];
                  end
               end else begin
                  w_cnt_nxt = r_cnt - CNT_ONE;
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   assign bus.HI   = r_hi;
   assign bus.LO   = r_lo;
   assign bus.busy = (r_state == ST_RUN);

endmodule

// File: tb/tb_mdu_multi.sv
// Bench for mdu_multi: timestamp-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mdu_multi;
   import mdu_pkg::*;

   localparam int W    = 32;
   localparam int MLAT = 5;
   localparam int DLAT = 10;

   logic clk;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   mdu_multi_if #(.WIDTH(W)) mif ();

   mdu_multi #(.WIDTH(W), .MUL_LAT(MLAT), .DIV_LAT(DLAT)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (mif.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference arithmetic: returns {div_zero, HI, LO}.
   function automatic logic [64:0] model_op(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] hi,
                                            input logic [31:0] lo);
      logic [63:0] acc;
      logic [63:0] ps;
      logic [63:0] pu;
      int          qa;
      int          ra;
      acc = {hi, lo};
      ps  = longint'($signed(a)) * longint'($signed(b));
      pu  = {32'd0, a} * {32'd0, b};
      case (op)
         MULT:  return {1'b0, ps};
         MULTU: return {1'b0, pu};
         MADD:  return {1'b0, acc + ps};
         MADDU: return {1'b0, acc + pu};
         MSUB:  return {1'b0, acc - ps};
         MSUBU: return {1'b0, acc - pu};
         DIV: begin
            if (b == 32'd0) return {1'b1, acc};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'd0, 32'h8000_0000};
            qa = int'(a) / int'(b);
            ra = int'(a) % int'(b);
            return {1'b0, 32'(ra), 32'(qa)};
         end
         DIVU: begin
            if (b == 32'd0) return {1'b1, acc};
            return {1'b0, a % b, a / b};
         end
         default: return {1'b0, acc};
      endcase
   endfunction

   // Model: an op issued at edge number t commits at edge t+LAT.
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;
   logic [63:0] m_res = '0;
   logic        m_dz = 1'b0;
   logic        m_act = 1'b0;
   logic        m_armed = 1'b0;
   longint      m_now = 0;
   longint      m_due = 0;

   always @(posedge clk) begin
      if (!rst) begin
         m_hi    <= '0;
         m_lo    <= '0;
         m_act   <= 1'b0;
         m_armed <= 1'b1;
      end else if (mif.kill) begin
         m_act <= 1'b0;
      end else if (m_act) begin
         if (m_now == m_due) begin
            m_act <= 1'b0;
            if (!m_dz) begin
               m_hi <= m_res[63:32];
               m_lo <= m_res[31:0];
            end
         end
      end else if (mif.start && mif.op <= 4'd9) begin
         if (mif.op == MTHI) m_hi <= mif.d1;
         else if (mif.op == MTLO) m_lo <= mif.d1;
         else begin
            {m_dz, m_res} <= model_op(mif.op, mif.d1, mif.d2, m_hi, m_lo);
            m_act <= 1'b1;
            m_due <= m_now + ((mif.op == DIV || mif.op == DIVU) ? DLAT : MLAT);
         end
      end
      m_now <= m_now + 1;
   end

   always @(negedge clk) begin
      if (m_armed) begin
         chk("model_hi", mif.HI, m_hi);
         chk("model_lo", mif.LO, m_lo);
         chk("model_busy", {31'd0, mif.busy}, {31'd0, m_act});
      end
   end

   task automatic drive(input bit s, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit k);
      mif.start = s;
      mif.op    = o;
      mif.d1    = a;
      mif.d2    = b;
      mif.kill  = k;
      @(negedge clk);
      mif.start = 1'b0;
      mif.kill  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, MULT, 32'd0, 32'd0, 1'b0);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'd1;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      rst       = 1'b0;
      mif.start = 1'b0;
      mif.op    = MULT;
      mif.d1    = '0;
      mif.d2    = '0;
      mif.kill  = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;

      // 1: reset values, MTHI
      chk("rst_hi", mif.HI, 32'd0);
      chk("rst_lo", mif.LO, 32'd0);
      chk("rst_busy", {31'd0, mif.busy}, 32'd0);
      drive(1'b1, MTHI, 32'h1234_5678, 32'd0, 1'b0);
      chk("mthi_hi", mif.HI, 32'h1234_5678);
      chk("mthi_busy", {31'd0, mif.busy}, 32'd0);

      // 2: MULT / MULTU
      drive(1'b1, MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
      n = 0;
      for (int i = 0; i < 8; i++) begin
         if (mif.busy) n++;
         idle(1);
      end
      chk("mult_busy_cycles", 32'(n), 32'd5);
      chk("mult_hi", mif.HI, 32'hFFFF_FFFF);
      chk("mult_lo", mif.LO, 32'hFFFF_FFEB);
      drive(1'b1, MULTU, 32'hFFFF_FFFD, 32'd7, 1'b0);
      idle(5);
      chk("multu_hi", mif.HI, 32'h0000_0006);
      chk("multu_lo", mif.LO, 32'hFFFF_FFEB);

      // 3: accumulate
      drive(1'b1, MTHI, 32'd0, 32'd0, 1'b0);
      drive(1'b1, MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0);
      drive(1'b1, MADDU, 32'd1, 32'd1, 1'b0);
      idle(5);
      chk("maddu_hi", mif.HI, 32'd1);
      chk("maddu_lo", mif.LO, 32'd0);
      drive(1'b1, MSUB, 32'd1, 32'd2, 1'b0);
      idle(5);
      chk("msub_hi", mif.HI, 32'd0);
      chk("msub_lo", mif.LO, 32'hFFFF_FFFE);

      // 4: division
      drive(1'b1, DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
      n = 0;
      for (int i = 0; i < 12; i++) begin
         if (mif.busy) n++;
         idle(1);
      end
      chk("div_busy_cycles", 32'(n), 32'd10);
      chk("div_lo", mif.LO, 32'hFFFF_FFFD);
      chk("div_hi", mif.HI, 32'hFFFF_FFFF);
      drive(1'b1, DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      idle(10);
      chk("divovf_lo", mif.LO, 32'h8000_0000);
      chk("divovf_hi", mif.HI, 32'd0);
      drive(1'b1, DIVU, 32'd99, 32'd0, 1'b0);
      idle(9);
      chk("divz_busy_last", {31'd0, mif.busy}, 32'd1);
      idle(1);
      chk("divz_busy_done", {31'd0, mif.busy}, 32'd0);
      chk("divz_lo", mif.LO, 32'h8000_0000);
      chk("divz_hi", mif.HI, 32'd0);

      // 5: start while busy, kill, start+kill
      drive(1'b1, DIVU, 32'd100, 32'd7, 1'b0);
      idle(1);
      drive(1'b1, MTLO, 32'h55, 32'd0, 1'b0);
      drive(1'b0, MULT, 32'd0, 32'd0, 1'b1);
      chk("kill_busy", {31'd0, mif.busy}, 32'd0);
      chk("kill_lo", mif.LO, 32'h8000_0000);
      chk("kill_hi", mif.HI, 32'd0);
      drive(1'b1, MTHI, 32'hDEAD, 32'd0, 1'b1);
      chk("startkill_hi", mif.HI, 32'd0);
      drive(1'b1, MULT, 32'd3, 32'd3, 1'b1);
      chk("startkill_busy", {31'd0, mif.busy}, 32'd0);
      idle(6);
      chk("startkill_lo", mif.LO, 32'h8000_0000);

      // 6: reset mid-operation
      drive(1'b1, MTHI, 32'hAAAA, 32'd0, 1'b0);
      drive(1'b1, MTLO, 32'hBBBB, 32'd0, 1'b0);
      drive(1'b1, MULT, 32'd2, 32'd3, 1'b0);
      idle(1);
      rst = 1'b0;
      idle(1);
      rst = 1'b1;
      chk("midrst_busy", {31'd0, mif.busy}, 32'd0);
      chk("midrst_hi", mif.HI, 32'd0);
      chk("midrst_lo", mif.LO, 32'd0);
      n = 0;
      for (int i = 0; i < 6; i++) begin
         if (mif.busy || mif.HI != 32'd0 || mif.LO != 32'd0) n++;
         idle(1);
      end
      chk("midrst_no_late_commit", 32'(n), 32'd0);

      // Randomized traffic, checked by the per-cycle model compare.
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 199) != 0);
         drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 11)), pick(), pick(),
               ($urandom_range(0, 29) == 0));
      end
      rst = 1'b1;
      idle(12);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
